// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the MINI-MIPS boot loader sequencer.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD_INST,
    ST_LOAD_DATA,
    ST_RUN,
    ST_HALTED
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int HDR_NI_MSB = 31;
  localparam int HDR_NI_LSB = 16;
  localparam int HDR_ND_MSB = 15;
  localparam int HDR_ND_LSB = 0;

  // Must stay a power of two: data addresses are built by shifting the beat index.
  localparam int DATA_BYTE_STRIDE = 4;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Loads header/instruction/data words from the host into core memories, then runs the core until halt or cycle limit.
// Writes land one cycle after the accepting edge at one word per cycle; s_valid low simply stalls the session.
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int          IADDR_W    = 10,
  parameter int          DADDR_W    = 10,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
  parameter int          MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  output logic               inst_we,
  output logic [IADDR_W-1:0] inst_write_address,
  output logic [31:0]        inst_write_data,
  output logic               mem_we,
  output logic [DADDR_W-1:0] mem_write_input_address,
  output logic [31:0]        mem_write_input_data,
  output logic               cpu_run,
  input  logic [31:0]        cpu_instr,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               hdr_err,
  output logic [31:0]        cycle_count
);

  localparam int STRIDE_SH = $clog2(DATA_BYTE_STRIDE);
  localparam int DIDX_W    = DADDR_W - STRIDE_SH;
  localparam int CNT_W     = ((IADDR_W > DIDX_W) ? IADDR_W : DIDX_W) + 1;
  localparam logic [32:0] NI_LIMIT = 33'd1 << IADDR_W;
  localparam logic [32:0] ND_LIMIT = 33'd1 << DIDX_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   ni_q, ni_d;
  logic [CNT_W-1:0]   nd_q, nd_d;
  logic               inst_we_q, inst_we_d;
  logic [IADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [31:0]        inst_data_q, inst_data_d;
  logic               mem_we_q, mem_we_d;
  logic [DADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic               cpu_run_q, cpu_run_d;
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               timeout_q, timeout_d;
  logic               hdr_err_q, hdr_err_d;

  logic        beat;
  logic [15:0] hdr_ni, hdr_nd;
  logic        hdr_ok;

  assign s_ready = (state_q == ST_HEADER) || (state_q == ST_LOAD_INST) || (state_q == ST_LOAD_DATA);
  assign beat    = s_valid && s_ready;
  assign hdr_ni  = s_data[HDR_NI_MSB:HDR_NI_LSB];
  assign hdr_nd  = s_data[HDR_ND_MSB:HDR_ND_LSB];
  assign hdr_ok  = ({17'd0, hdr_ni} <= NI_LIMIT) && ({17'd0, hdr_nd} <= ND_LIMIT);

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    ni_d          = ni_q;
    nd_d          = nd_q;
    inst_we_d     = 1'b0;
    inst_addr_d   = inst_addr_q;
    inst_data_d   = inst_data_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    hdr_err_d     = hdr_err_q;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d       = ST_HEADER;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          hdr_err_d     = 1'b0;
        end
      end
      ST_HEADER: begin
        if (beat) begin
          ni_d       = CNT_W'(hdr_ni);
          nd_d       = CNT_W'(hdr_nd);
          beat_cnt_d = '0;
          if (!hdr_ok) begin
            hdr_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (hdr_ni != 16'd0) begin
            state_d = ST_LOAD_INST;
          end else if (hdr_nd != 16'd0) begin
            state_d = ST_LOAD_DATA;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_LOAD_INST: begin
        if (beat) begin
          inst_we_d   = 1'b1;
          inst_addr_d = beat_cnt_q[IADDR_W-1:0];
          inst_data_d = s_data;
          beat_cnt_d  = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q + CNT_W'(1) == ni_q) begin
            beat_cnt_d = '0;
            state_d    = (nd_q != '0) ? ST_LOAD_DATA : ST_RUN;
          end
        end
      end
      ST_LOAD_DATA: begin
        if (beat) begin
          mem_we_d   = 1'b1;
          mem_addr_d = {beat_cnt_q[DIDX_W-1:0], {STRIDE_SH{1'b0}}};
          mem_data_d = s_data;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q + CNT_W'(1) == nd_q) begin
            beat_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // The first RUN cycle holds the core in reset while the last write lands; cpu_instr is ignored there.
        if (cpu_run_q) begin
          if (cpu_instr == HALT_WORD) begin
            state_d = ST_HALTED;
          end else begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (cycle_count_q == 32'(MAX_CYCLES - 1)) begin
              state_d   = ST_HALTED;
              timeout_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_run_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      ni_q          <= '0;
      nd_q          <= '0;
      inst_we_q     <= 1'b0;
      inst_addr_q   <= '0;
      inst_data_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      cpu_run_q     <= 1'b0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      hdr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      ni_q          <= ni_d;
      nd_q          <= nd_d;
      inst_we_q     <= inst_we_d;
      inst_addr_q   <= inst_addr_d;
      inst_data_q   <= inst_data_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      cpu_run_q     <= cpu_run_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      hdr_err_q     <= hdr_err_d;
    end
  end

  assign inst_we                 = inst_we_q;
  assign inst_write_address      = inst_addr_q;
  assign inst_write_data         = inst_data_q;
  assign mem_we                  = mem_we_q;
  assign mem_write_input_address = mem_addr_q;
  assign mem_write_input_data    = mem_data_q;
  assign cpu_run                 = cpu_run_q;
  assign busy                    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign done                    = (state_q == ST_HALTED);
  assign timeout                 = timeout_q;
  assign hdr_err                 = hdr_err_q;
  assign cycle_count             = cycle_count_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized sessions against a queue-based model of expected writes and run/halt arithmetic.
module tb_boot_loader_ctrl;

  localparam int IADDR_W = 10;
  localparam int DADDR_W = 10;
  localparam int MAXC    = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [31:0]        s_data = '0;
  logic               inst_we;
  logic [IADDR_W-1:0] inst_write_address;
  logic [31:0]        inst_write_data;
  logic               mem_we;
  logic [DADDR_W-1:0] mem_write_input_address;
  logic [31:0]        mem_write_input_data;
  logic               cpu_run;
  logic [31:0]        cpu_instr = HALT;
  logic               busy, done, timeout, hdr_err;
  logic [31:0]        cycle_count;

  boot_loader_ctrl #(
    .IADDR_W(IADDR_W), .DADDR_W(DADDR_W), .HALT_WORD(HALT), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .inst_we(inst_we), .inst_write_address(inst_write_address), .inst_write_data(inst_write_data),
    .mem_we(mem_we), .mem_write_input_address(mem_write_input_address),
    .mem_write_input_data(mem_write_input_data),
    .cpu_run(cpu_run), .cpu_instr(cpu_instr),
    .busy(busy), .done(done), .timeout(timeout), .hdr_err(hdr_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nbad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t qi[$];
  wr_t qm[$];
  wr_t ei, em;
  logic [31:0] src_words[$];
  int n_inst_wr = 0;
  logic [31:0] last_inst_addr = '0;
  logic [31:0] last_mem_addr = '0;

  function automatic void push_w(input bit is_mem, input int a, input logic [31:0] d, input int at);
    wr_t e;
    e.addr = 32'(a);
    e.data = d;
    e.at   = at;
    if (is_mem) qm.push_back(e);
    else qi.push_back(e);
  endfunction

  function automatic logic [31:0] next_word();
    if (src_words.size() > 0) return src_words.pop_front();
    return $urandom;
  endfunction

  // Every write strobe must match the oldest expected write, in the cycle after its beat was accepted.
  always @(negedge clk) begin
    if (inst_we === 1'b1) begin
      n_inst_wr++;
      last_inst_addr = 32'(inst_write_address);
      if (qi.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL inst_wr_unexpected: addr 0x%0h, none required", inst_write_address);
      end else begin
        ei = qi.pop_front();
        chk("inst_addr", 32'(inst_write_address), ei.addr);
        chk("inst_data", inst_write_data, ei.data);
        chk("inst_wr_cycle", 32'(cyc), 32'(ei.at));
      end
    end
    if (mem_we === 1'b1) begin
      last_mem_addr = 32'(mem_write_input_address);
      if (qm.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL mem_wr_unexpected: addr 0x%0h, none required", mem_write_input_address);
      end else begin
        em = qm.pop_front();
        chk("mem_addr", 32'(mem_write_input_address), em.addr);
        chk("mem_data", mem_write_input_data, em.data);
        chk("mem_wr_cycle", 32'(cyc), 32'(em.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, output int acc);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    while (!got && n < 40) begin
      @(negedge clk);
      got = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    s_data  = $urandom;
    acc = cyc;
    if (!got) begin
      nvec++; nbad++;
      $display("FAIL send_timeout: word 0x%0h not accepted in 40 cycles", w);
    end
  endtask

  // Idle cycles inside a session; stray start pulses here must be ignored.
  task automatic gap(input int mode);
    int n;
    n = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < n; g++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("ready_in_gap", 32'(s_ready), 32'd1);
      chk("busy_in_gap", 32'(busy), 32'd1);
      tick();
      start = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({s_ready, inst_we, mem_we, cpu_run, busy, done, timeout, hdr_err}), 32'd0);
    chk({tag, "_iaddr"}, 32'(inst_write_address), 32'd0);
    chk({tag, "_idata"}, inst_write_data, 32'd0);
    chk({tag, "_maddr"}, 32'(mem_write_input_address), 32'd0);
    chk({tag, "_mdata"}, mem_write_input_data, 32'd0);
    chk({tag, "_count"}, cycle_count, 32'd0);
  endtask

  // Full session; returns at the negedge of the first cycle the core should be running.
  task automatic load(input int ni, input int nd, input int mode);
    int t;
    logic [31:0] w;
    cpu_instr = HALT;
    pulse_start();
    @(negedge clk);
    chk("hdr_ready", 32'(s_ready), 32'd1);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("start_clears_flags", 32'({timeout, hdr_err, done}), 32'd0);
    chk("start_clears_count", cycle_count, 32'd0);
    tick();
    send((32'(ni) << 16) | 32'(nd), t);
    for (int k = 0; k < ni; k++) begin
      if (k > 0) gap(mode);
      w = next_word();
      send(w, t);
      push_w(1'b0, k, w, t);
    end
    for (int k = 0; k < nd; k++) begin
      if (ni > 0 || k > 0) gap(mode);
      w = next_word();
      send(w, t);
      push_w(1'b1, k * 4, w, t);
    end
    @(negedge clk);
    chk("run_not_before_last_write", 32'(cpu_run), 32'd0);
    chk("busy_last_write", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("run_rise", 32'(cpu_run), 32'd1);
    chk("inst_writes_outstanding", 32'(qi.size()), 32'd0);
    chk("mem_writes_outstanding", 32'(qm.size()), 32'd0);
  endtask

  // halt_at < 0 means never halt; the model stops at min(halt_at, MAXC-1) with halt winning ties.
  task automatic run_phase(input int halt_at);
    int  stop, final_cnt;
    bit  to;
    logic [31:0] w;
    to        = !(halt_at >= 0 && halt_at <= MAXC - 1);
    stop      = to ? MAXC - 1 : halt_at;
    final_cnt = to ? MAXC : halt_at;
    for (int i = 0; i <= stop; i++) begin
      if (i > 0) @(negedge clk);
      chk("run_count", cycle_count, 32'(i));
      chk("run_on", 32'(cpu_run), 32'd1);
      w = $urandom;
      if (w == HALT) w = 32'd0;
      cpu_instr = (i == halt_at) ? HALT : w;
      tick();
    end
    @(negedge clk);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_run_off", 32'(cpu_run), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_count", cycle_count, 32'(final_cnt));
    chk("halt_timeout", 32'(timeout), 32'(to));
    cpu_instr = $urandom;
    repeat (3) tick();
    @(negedge clk);
    chk("halt_count_frozen", cycle_count, 32'(final_cnt));
    chk("halt_done_held", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [31:0] w;

    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Beats offered in IDLE are not consumed.
    s_valid = 1'b1;
    s_data  = 32'h0001_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("idle_not_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    tick();

    // Back-to-back session with fixed words, pinned by hand.
    src_words = '{32'hA, 32'hB, 32'hC, 32'h4, 32'h2};
    n_inst_wr = 0;
    load(3, 2, 0);
    chk("t1_inst_writes", 32'(n_inst_wr), 32'd3);
    chk("t1_last_mem_addr", last_mem_addr, 32'd4);
    run_phase(2);

    // Same session with s_valid toggling.
    src_words = '{32'hA, 32'hB, 32'hC, 32'h4, 32'h2};
    n_inst_wr = 0;
    load(3, 2, 1);
    chk("t2_inst_writes", 32'(n_inst_wr), 32'd3);
    run_phase(0);

    // Empty program, halt after five run cycles.
    load(0, 0, 0);
    run_phase(5);
    chk("t3_count_literal", cycle_count, 32'd5);

    // Oversized headers are rejected.
    for (int h = 0; h < 2; h++) begin
      pulse_start();
      tick();
      send((h == 0) ? 32'h0401_0000 : 32'h0000_0101, t);
      @(negedge clk);
      chk("hdr_err_set", 32'(hdr_err), 32'd1);
      chk("hdr_err_idle", 32'({s_ready, busy, done, cpu_run}), 32'd0);
      s_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick();
        @(negedge clk);
        chk("hdr_err_not_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      tick();
    end

    // Cycle limit, then halt tying with the limit.
    load(1, 1, 0);
    run_phase(-1);
    chk("timeout_literal", 32'({timeout, cycle_count[7:0]}), 32'h108);
    load(0, 1, 2);
    run_phase(MAXC - 1);

    // Reset mid-load after two of four beats.
    pulse_start();
    tick();
    send(32'h0004_0000, t);
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      send(w, t);
      push_w(1'b0, k, w, t);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    chk("mid_reset_writes", 32'(qi.size()), 32'd0);
    load(4, 0, 2);
    run_phase(3);

    // Reset wins over a simultaneous start from HALTED.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_zero("rst_over_start");
    tick();

    // Largest legal header: no address wrap.
    load(1024, 256, 0);
    chk("max_last_inst_addr", last_inst_addr, 32'd1023);
    chk("max_last_mem_addr", last_mem_addr, 32'd1020);
    run_phase(1);

    for (int r = 0; r < 8; r++) begin
      load(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 2);
      run_phase(int'($urandom_range(0, 10)) - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Sequencer that brings the MINI-MIPS core from reset to a running program. It accepts a word stream from a host, writes the instruction words into instruction memory and the data words into data memory through the core's existing load ports, then releases the core. It watches the fetched instruction for the halt word and stops the core, reporting completion and the run-cycle count. It sits between the host link and `main`, and replaces the hand-sequenced writes a testbench would otherwise perform.

## Interface
- `IADDR_W`, 10: instruction memory address width, in word addresses.
- `DADDR_W`, 10: data memory address width, in byte addresses.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that terminates a run.
- `MAX_CYCLES`, 100000: run-cycle limit before a forced stop.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that opens a load session. Honoured only in IDLE or HALTED.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 32: host word stream. A beat transfers when `s_valid && s_ready`.
- `inst_we` out 1, `inst_write_address` out IADDR_W, `inst_write_data` out 32: instruction memory write port.
- `mem_we` out 1, `mem_write_input_address` out DADDR_W, `mem_write_input_data` out 32: data memory write port.
- `cpu_run` out 1: core enable. The top level derives the core reset from `!cpu_run`.
- `cpu_instr` in 32: instruction the core is currently fetching.
- `busy` out 1: high in every state except IDLE and HALTED.
- `done` out 1: high in HALTED.
- `timeout` out 1: sticky; set when a run is stopped by `MAX_CYCLES`.
- `hdr_err` out 1: sticky; set when a header is rejected.
- `cycle_count` out 32: number of RUN cycles in the last or current run.

## Operation
- States: IDLE, HEADER, LOAD_INST, LOAD_DATA, RUN, HALTED.
- IDLE / HALTED -> HEADER on `start`. This transition clears `cycle_count`, `timeout` and `hdr_err`.
- HEADER: `s_ready`=1. The first beat is the header: `N_I` = `s_data[31:16]`, `N_D` = `s_data[15:0]`.
  - If `N_I > 2^IADDR_W` or `N_D > 2^DADDR_W/4`: set `hdr_err` and go to IDLE.
  - Else go to LOAD_INST if `N_I`≠0, else LOAD_DATA if `N_D`≠0, else RUN.
- LOAD_INST: `s_ready`=1. Beat k (k = 0..N_I-1) writes instruction address k. After beat N_I-1, go to LOAD_DATA, or to RUN if `N_D`=0.
- LOAD_DATA: `s_ready`=1. Beat k writes data memory byte address 4k. After beat N_D-1, go to RUN.
- RUN: `cpu_run`=1 and `cycle_count` increments every cycle.
  - `cpu_instr == HALT_WORD` -> HALTED.
  - `cycle_count == MAX_CYCLES-1` -> HALTED with `timeout` set.
  - If both occur in the same cycle, the halt takes priority: `timeout` is not set.
- HALTED: `cpu_run`=0 and `done`=1; memories keep their contents.
- `s_ready`=0 in IDLE, RUN and HALTED. Beats offered in those states are not consumed.
- Beat counters are `IADDR_W`+1 bits wide, so `N_I` = 2^IADDR_W completes without wrapping. Addresses never wrap within a session.

## Timing
- Reset: state IDLE. All outputs are 0, including `s_ready`, `inst_we`, `mem_we`, the addresses, the data, `cpu_run`, `done`, the flags and `cycle_count`.
- `rst` overrides `start` in the same cycle.
- Reset during a load or run aborts the session. Words already written remain in memory; nothing is cleared.
- Write latency:
  - A beat accepted at edge t drives `inst_we`/`mem_we` high for exactly the cycle after t.
  - Address and data are registered alongside the write enable and are valid while it is high.
  - Writes are one cycle wide; throughput is one word per cycle.
- Back-pressure: `s_valid` low stalls the session indefinitely with no write. The host may drop and reassert `s_valid` freely.
- `cpu_run` rises the cycle after the last beat's write enable, so the final write completes before the core leaves reset.
- Halt: `cpu_instr` == `HALT_WORD` sampled at edge t makes `cpu_run` 0 and `done` 1 from t onward. `cycle_count` freezes at its value at t.
- `start` pulses while `busy`=1 are ignored.

## Structure
- Package `boot_loader_pkg`:
  - state enum type;
  - `HALT_WORD_DEFAULT`;
  - header field positions (`HDR_NI_MSB/LSB`, `HDR_ND_MSB/LSB`);
  - data stride constant `DATA_BYTE_STRIDE` = 4.
- Single module with no sub-module. The FSM, beat counter, write register stage and run counter all live in `boot_loader_ctrl`.

## Test plan
- Header 0x0003_0002, then instructions A,B,C and data 4,2 sent back to back. Expect `inst_we` at addresses 0,1,2 on three consecutive cycles, then `mem_we` at addresses 0,4. `cpu_run` rises one cycle after the last write.
- Same session with `s_valid` toggling every other cycle. Expect identical writes in the same order with gaps and no duplicates; `s_ready` stays 1 throughout.
- Header 0x0000_0000. Expect no writes and `cpu_run`=1 two cycles after the header beat. Drive `cpu_instr`=0xFFFF_FFFF after 5 RUN cycles: expect `done`=1, `cpu_run`=0, `cycle_count`=5.
- Header 0x0401_0000 with `IADDR_W`=10. Expect `hdr_err`=1, return to IDLE, `s_ready`=0 and no writes.
- With `MAX_CYCLES`=8 and `cpu_instr` never halting, expect HALTED after 8 RUN cycles with `timeout`=1.
- `rst` asserted mid-LOAD_INST after 2 of 4 beats. Expect all outputs 0 on the next cycle. A new `start` then completes a full session normally.
